// File: rtl/wav_dfi_ctrl_arb.sv
// rtl/wav_dfi_ctrl_arb.sv - MC-side DFI control-plane arbiter
//
// Serializes every non-datapath DFI handshake (init, ctrlupd, phyupd,
// phymstr, lp_ctrl/lp_data) through one state machine so that no two of
// them are ever active together, enforces the tlp_resp / tctrlupd /
// tphyupd_resp windows and tells the scheduler when to stop issuing.
//
// Ports:
//   clock_i, reset_i        sole clock, synchronous active-high reset
//   mc_init_req_i           one-cycle init request pulse from the scheduler
//   mc_ctrlupd_req_i        level request for a controller update
//   mc_lp_req_i             level low-power request (low = request exit)
//   mc_lp_wakeup_i          wakeup code, latched when the lp request issues
//   mc_idle_i               scheduler has drained all DFI traffic
//   init_complete_i, ctrlupd_ack_i, phyupd_req_i, phyupd_type_i,
//   phymstr_req_i, phymstr_type_i, lp_ctrl_ack_i, lp_data_ack_i
//                           DFI inputs from the PHY
//   init_start_o, ctrlupd_req_o, phyupd_ack_o, phymstr_ack_o,
//   lp_ctrl_req_o, lp_data_req_o, lp_ctrl_wakeup_o, lp_data_wakeup_o
//                           DFI outputs to the PHY
//   mc_block_o              scheduler must stop issuing commands
//   lp_active_o             low-power handshake completed and held
//   upd_type_o              type latched at phyupd/phymstr grant
//   err_resp_late_o         pulse when a PHY request was acked too late

module wav_dfi_ctrl_arb #(
   parameter int TLP_RESP     = 8,
   parameter int TCTRLUPD_MIN = 4,
   parameter int TCTRLUPD_MAX = 32,
   parameter int TPHYUPD_RESP = 16,
   parameter int CNT_W        = 8
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       mc_init_req_i,
   input  logic       mc_ctrlupd_req_i,
   input  logic       mc_lp_req_i,
   input  logic [5:0] mc_lp_wakeup_i,
   input  logic       mc_idle_i,
   input  logic       init_complete_i,
   input  logic       ctrlupd_ack_i,
   input  logic       phyupd_req_i,
   input  logic [1:0] phyupd_type_i,
   input  logic       phymstr_req_i,
   input  logic [1:0] phymstr_type_i,
   input  logic       lp_ctrl_ack_i,
   input  logic       lp_data_ack_i,
   output logic       init_start_o,
   output logic       ctrlupd_req_o,
   output logic       phyupd_ack_o,
   output logic       phymstr_ack_o,
   output logic       lp_ctrl_req_o,
   output logic       lp_data_req_o,
   output logic [5:0] lp_ctrl_wakeup_o,
   output logic [5:0] lp_data_wakeup_o,
   output logic       mc_block_o,
   output logic       lp_active_o,
   output logic [1:0] upd_type_o,
   output logic       err_resp_late_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_CTRLUPD,
      ST_PHYUPD,
      ST_PHYMSTR,
      ST_LP_REQ,
      ST_LP_HOLD,
      ST_LP_EXIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LP_LIM   = CNT_W'(TLP_RESP);
   localparam logic [CNT_W-1:0] CU_MIN   = CNT_W'(TCTRLUPD_MIN);
   localparam logic [CNT_W-1:0] CU_MAX   = CNT_W'(TCTRLUPD_MAX);
   localparam logic [CNT_W-1:0] RESP_LIM = CNT_W'(TPHYUPD_RESP);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] upd_wait_q, upd_wait_d;
   logic [CNT_W-1:0] mstr_wait_q, mstr_wait_d;
   logic             init_pend_q, init_pend_d;
   logic             ctrl_seen_q, ctrl_seen_d;
   logic             lp_arm_q, lp_arm_d;

   logic             init_start_q, init_start_d;
   logic             ctrlupd_req_q, ctrlupd_req_d;
   logic             phyupd_ack_q, phyupd_ack_d;
   logic             phymstr_ack_q, phymstr_ack_d;
   logic             lp_req_q, lp_req_d;
   logic [5:0]       wakeup_q, wakeup_d;
   logic             mc_block_q, mc_block_d;
   logic             lp_active_q, lp_active_d;
   logic [1:0]       upd_type_q, upd_type_d;
   logic             err_q, err_d;

   logic             entering;
   logic             lp_both_ack;

   assign lp_both_ack = lp_ctrl_ack_i & lp_data_ack_i;

   // State register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, window counters and next values of every registered output.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
      init_pend_d = init_pend_q | mc_init_req_i;
      ctrl_seen_d = ctrl_seen_q;
      // An lp request that timed out is re-armed only once mc_lp_req drops.
      lp_arm_d    = lp_arm_q | ~mc_lp_req_i;
      entering    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (init_pend_q | mc_init_req_i) begin
               state_d = ST_INIT;
            end else if (phymstr_req_i & mc_idle_i) begin
               state_d = ST_PHYMSTR;
            end else if (phyupd_req_i & mc_idle_i) begin
               state_d = ST_PHYUPD;
            end else if (mc_ctrlupd_req_i & mc_idle_i) begin
               state_d = ST_CTRLUPD;
            end else if (mc_lp_req_i & mc_idle_i & lp_arm_q) begin
               state_d = ST_LP_REQ;
            end
         end
         ST_INIT: begin
            if (init_complete_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_PHYMSTR: begin
            if (!phymstr_req_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_PHYUPD: begin
            if (!phyupd_req_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_CTRLUPD: begin
            ctrl_seen_d = ctrl_seen_q | ctrlupd_ack_i;
            if (ctrl_seen_q | ctrlupd_ack_i) begin
               // Acked: hold until the ack falls or the max window closes.
               if ((ctrl_seen_q & ~ctrlupd_ack_i) | (cnt_q == CU_MAX)) begin
                  state_d = ST_IDLE;
               end
            end else if (cnt_q == CU_MIN) begin
               state_d = ST_IDLE;
            end
         end
         ST_LP_REQ: begin
            if (lp_both_ack) begin
               state_d = ST_LP_HOLD;
            end else if (cnt_q == LP_LIM) begin
               state_d  = ST_IDLE;
               lp_arm_d = ~mc_lp_req_i;
            end
         end
         ST_LP_HOLD: begin
            if (!mc_lp_req_i) begin
               state_d = ST_LP_EXIT;
            end
         end
         ST_LP_EXIT: begin
            if (!lp_ctrl_ack_i && !lp_data_ack_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The window counter includes the entry cycle, so it starts at 1.
      if (state_d != state_q) begin
         entering = 1'b1;
         cnt_d    = CNT_ONE;
      end
      if (entering && (state_d == ST_INIT)) begin
         init_pend_d = 1'b0;
      end
      if (entering && (state_d == ST_CTRLUPD)) begin
         ctrl_seen_d = 1'b0;
      end

      // Ungranted-request age; frozen while granted, cleared when req drops.
      if (!phyupd_req_i) begin
         upd_wait_d = '0;
      end else if (state_d == ST_PHYUPD) begin
         upd_wait_d = upd_wait_q;
      end else begin
         upd_wait_d = (upd_wait_q == CNT_SAT) ? upd_wait_q : upd_wait_q + CNT_ONE;
      end
      if (!phymstr_req_i) begin
         mstr_wait_d = '0;
      end else if (state_d == ST_PHYMSTR) begin
         mstr_wait_d = mstr_wait_q;
      end else begin
         mstr_wait_d = (mstr_wait_q == CNT_SAT) ? mstr_wait_q : mstr_wait_q + CNT_ONE;
      end

      // DFI outputs follow the state one edge later, which guarantees an
      // idle cycle between the release of one handshake and the next grant.
      init_start_d  = (state_q == ST_INIT);
      ctrlupd_req_d = (state_q == ST_CTRLUPD);
      // An ack only rises while the PHY req is still high.
      phyupd_ack_d  = (state_q == ST_PHYUPD) & (phyupd_ack_q | phyupd_req_i);
      phymstr_ack_d = (state_q == ST_PHYMSTR) & (phymstr_ack_q | phymstr_req_i);
      lp_req_d      = (state_q == ST_LP_REQ) | (state_q == ST_LP_HOLD);
      lp_active_d   = (state_q == ST_LP_HOLD);

      wakeup_d = wakeup_q;
      if (entering && (state_d == ST_LP_REQ)) begin
         wakeup_d = mc_lp_wakeup_i;
      end
      upd_type_d = upd_type_q;
      if (entering && (state_d == ST_PHYMSTR)) begin
         upd_type_d = phymstr_type_i;
      end else if (entering && (state_d == ST_PHYUPD)) begin
         upd_type_d = phyupd_type_i;
      end

      mc_block_d = (state_d != ST_IDLE) | phyupd_req_i | phymstr_req_i | init_pend_d;

      // Late flag fires on the cycle the ack first rises.
      err_d = ((state_q == ST_PHYUPD) & ~phyupd_ack_q & phyupd_req_i &
               (upd_wait_q > RESP_LIM)) |
              ((state_q == ST_PHYMSTR) & ~phymstr_ack_q & phymstr_req_i &
               (mstr_wait_q > RESP_LIM));
   end

   // Counters, flags and output registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q         <= '0;
         upd_wait_q    <= '0;
         mstr_wait_q   <= '0;
         init_pend_q   <= 1'b0;
         ctrl_seen_q   <= 1'b0;
         lp_arm_q      <= 1'b1;
         init_start_q  <= 1'b0;
         ctrlupd_req_q <= 1'b0;
         phyupd_ack_q  <= 1'b0;
         phymstr_ack_q <= 1'b0;
         lp_req_q      <= 1'b0;
         wakeup_q      <= '0;
         mc_block_q    <= 1'b0;
         lp_active_q   <= 1'b0;
         upd_type_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         upd_wait_q    <= upd_wait_d;
         mstr_wait_q   <= mstr_wait_d;
         init_pend_q   <= init_pend_d;
         ctrl_seen_q   <= ctrl_seen_d;
         lp_arm_q      <= lp_arm_d;
         init_start_q  <= init_start_d;
         ctrlupd_req_q <= ctrlupd_req_d;
         phyupd_ack_q  <= phyupd_ack_d;
         phymstr_ack_q <= phymstr_ack_d;
         lp_req_q      <= lp_req_d;
         wakeup_q      <= wakeup_d;
         mc_block_q    <= mc_block_d;
         lp_active_q   <= lp_active_d;
         upd_type_q    <= upd_type_d;
         err_q         <= err_d;
      end
   end

   assign init_start_o     = init_start_q;
   assign ctrlupd_req_o    = ctrlupd_req_q;
   assign phyupd_ack_o     = phyupd_ack_q;
   assign phymstr_ack_o    = phymstr_ack_q;
   assign lp_ctrl_req_o    = lp_req_q;
   assign lp_data_req_o    = lp_req_q;
   assign lp_ctrl_wakeup_o = wakeup_q;
   assign lp_data_wakeup_o = wakeup_q;
   assign mc_block_o       = mc_block_q;
   assign lp_active_o      = lp_active_q;
   assign upd_type_o       = upd_type_q;
   assign err_resp_late_o  = err_q;

endmodule

// File: tb/tb_wav_dfi_ctrl_arb.sv
// tb/tb_wav_dfi_ctrl_arb.sv - directed self-checking bench for wav_dfi_ctrl_arb

module tb_wav_dfi_ctrl_arb;

   logic       clk;
   logic       reset;
   logic       mc_init_req, mc_ctrlupd_req, mc_lp_req, mc_idle;
   logic [5:0] mc_lp_wakeup;
   logic       init_complete, ctrlupd_ack, phyupd_req, phymstr_req;
   logic [1:0] phyupd_type, phymstr_type;
   logic       lp_ctrl_ack, lp_data_ack;
   logic       init_start, ctrlupd_req, phyupd_ack, phymstr_ack;
   logic       lp_ctrl_req, lp_data_req, mc_block, lp_active, err_resp_late;
   logic [5:0] lp_ctrl_wakeup, lp_data_wakeup;
   logic [1:0] upd_type;
   logic [22:0] outs;

   int n_chk;
   int n_fail;

   assign outs = {init_start, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req,
                  lp_data_req, lp_ctrl_wakeup, lp_data_wakeup, mc_block,
                  lp_active, upd_type, err_resp_late};

   wav_dfi_ctrl_arb dut (
      .clock_i          (clk),
      .reset_i          (reset),
      .mc_init_req_i    (mc_init_req),
      .mc_ctrlupd_req_i (mc_ctrlupd_req),
      .mc_lp_req_i      (mc_lp_req),
      .mc_lp_wakeup_i   (mc_lp_wakeup),
      .mc_idle_i        (mc_idle),
      .init_complete_i  (init_complete),
      .ctrlupd_ack_i    (ctrlupd_ack),
      .phyupd_req_i     (phyupd_req),
      .phyupd_type_i    (phyupd_type),
      .phymstr_req_i    (phymstr_req),
      .phymstr_type_i   (phymstr_type),
      .lp_ctrl_ack_i    (lp_ctrl_ack),
      .lp_data_ack_i    (lp_data_ack),
      .init_start_o     (init_start),
      .ctrlupd_req_o    (ctrlupd_req),
      .phyupd_ack_o     (phyupd_ack),
      .phymstr_ack_o    (phymstr_ack),
      .lp_ctrl_req_o    (lp_ctrl_req),
      .lp_data_req_o    (lp_data_req),
      .lp_ctrl_wakeup_o (lp_ctrl_wakeup),
      .lp_data_wakeup_o (lp_data_wakeup),
      .mc_block_o       (mc_block),
      .lp_active_o      (lp_active),
      .upd_type_o       (upd_type),
      .err_resp_late_o  (err_resp_late)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // PHY update held ungranted for d cycles by mc_idle low.
   task automatic phy_late(input int d, input int exp_err);
      int errs;
      errs = 0;
      mc_idle = 1'b0;
      phyupd_type = 2'd1;
      phyupd_req = 1'b1;
      repeat (d) tick;
      mc_idle = 1'b1;
      repeat (6) begin
         tick;
         if (err_resp_late) errs++;
      end
      check($sformatf("late_err_d%0d", d), errs, exp_err);
      check($sformatf("late_ack_d%0d", d), phyupd_ack, 1);
      phyupd_req = 1'b0;
      repeat (3) tick;
      check($sformatf("late_rel_d%0d", d), phyupd_ack, 0);
   endtask

   // One ctrlupd request; ack driven high after tick ack_on, low after ack_off.
   task automatic ctrl_run(input int ack_on, input int ack_off, input int exp_hi);
      int hi;
      hi = 0;
      mc_idle = 1'b1;
      mc_ctrlupd_req = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         tick;
         if (ctrlupd_req) hi++;
         if (i == 1) mc_ctrlupd_req = 1'b0;
         if (i == ack_on) ctrlupd_ack = 1'b1;
         if (i == ack_off) ctrlupd_ack = 1'b0;
      end
      check($sformatf("ctrl_hi_%0d", exp_hi), hi, exp_hi);
      check($sformatf("ctrl_blk_%0d", exp_hi), mc_block, 0);
   endtask

   initial begin
      int hi, hi2, first_m, first_u, overlap, errs;
      n_chk = 0;
      n_fail = 0;
      reset = 1'b1;
      {mc_init_req, mc_ctrlupd_req, mc_lp_req, mc_idle} = '0;
      mc_lp_wakeup = '0;
      {init_complete, ctrlupd_ack, phyupd_req, phymstr_req} = '0;
      phyupd_type = '0;
      phymstr_type = '0;
      {lp_ctrl_ack, lp_data_ack} = '0;
      repeat (2) tick;
      check("reset_outs", outs, 0);
      reset = 1'b0;
      tick;
      check("idle_block", mc_block, 0);

      // Init handshake
      mc_init_req = 1'b1;
      tick;
      mc_init_req = 1'b0;
      check("init_lag", init_start, 0);
      check("init_block", mc_block, 1);
      tick;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (init_start) hi++;
         if (i == 19) init_complete = 1'b1;
         tick;
      end
      check("init_hi", hi, 20);
      check("init_still", init_start, 1);
      check("init_block_off", mc_block, 0);
      init_complete = 1'b0;
      tick;
      check("init_drop", init_start, 0);

      // Phyupd grant/release
      mc_idle = 1'b1;
      phyupd_type = 2'd2;
      phyupd_req = 1'b1;
      tick;
      check("upd_lag", phyupd_ack, 0);
      check("upd_type", upd_type, 2);
      tick;
      check("upd_ack", phyupd_ack, 1);
      check("upd_noerr", err_resp_late, 0);
      phyupd_req = 1'b0;
      tick;
      check("upd_hold", phyupd_ack, 1);
      tick;
      check("upd_rel", phyupd_ack, 0);
      phy_late(16, 0);
      phy_late(20, 1);

      // Collision phymstr/phyupd
      mc_idle = 1'b1;
      phymstr_type = 2'd3;
      phyupd_type = 2'd1;
      phymstr_req = 1'b1;
      phyupd_req = 1'b1;
      first_m = -1;
      first_u = -1;
      overlap = 0;
      errs = 0;
      for (int i = 1; i <= 15; i++) begin
         tick;
         if (phymstr_ack && phyupd_ack) overlap++;
         if (err_resp_late) errs++;
         if (phymstr_ack && first_m < 0) first_m = i;
         if (phyupd_ack && first_u < 0) first_u = i;
         if (i == 3) check("col_type_m", upd_type, 3);
         if (i == 5) phymstr_req = 1'b0;
      end
      check("col_first_m", first_m, 2);
      check("col_first_u", first_u, 8);
      check("col_overlap", overlap, 0);
      check("col_err", errs, 0);
      check("col_type_u", upd_type, 1);
      phyupd_req = 1'b0;
      repeat (3) tick;

      // Ctrlupd windows
      ctrl_run(0, 0, 4);
      ctrl_run(2, 42, 32);
      ctrl_run(2, 6, 6);

      // LP timeout, no retry while mc_lp_req stays high
      mc_lp_wakeup = 6'h2A;
      mc_lp_req = 1'b1;
      hi = 0;
      hi2 = 0;
      for (int i = 1; i <= 14; i++) begin
         tick;
         if (lp_ctrl_req) hi++;
         if (lp_data_req) hi2++;
      end
      check("lp_to_ctrl", hi, 8);
      check("lp_to_data", hi2, 8);
      check("lp_wake_c", lp_ctrl_wakeup, 6'h2A);
      check("lp_wake_d", lp_data_wakeup, 6'h2A);
      mc_lp_req = 1'b0;
      repeat (2) tick;

      // LP enter, hold, exit
      mc_lp_wakeup = 6'h15;
      mc_lp_req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick;
         if (i == 3) begin
            lp_ctrl_ack = 1'b1;
            lp_data_ack = 1'b1;
         end
      end
      check("lp_active", lp_active, 1);
      check("lp_hold_req", {lp_ctrl_req, lp_data_req}, 2'b11);
      check("lp_hold_wake", lp_ctrl_wakeup, 6'h15);
      mc_lp_req = 1'b0;
      tick;
      tick;
      check("lp_exit_req", {lp_ctrl_req, lp_data_req}, 2'b00);
      check("lp_exit_act", lp_active, 0);
      check("lp_exit_blk", mc_block, 1);
      mc_lp_req = 1'b1;
      repeat (2) tick;
      check("lp_exit_norearm", lp_ctrl_req, 0);
      mc_lp_req = 1'b0;
      lp_ctrl_ack = 1'b0;
      lp_data_ack = 1'b0;
      repeat (2) tick;
      check("lp_idle_blk", mc_block, 0);

      // Reset during LP_HOLD
      mc_lp_req = 1'b1;
      repeat (2) tick;
      lp_ctrl_ack = 1'b1;
      lp_data_ack = 1'b1;
      repeat (4) tick;
      check("rst_lp_pre", lp_active, 1);
      reset = 1'b1;
      tick;
      check("rst_lp_outs", outs, 0);
      mc_lp_req = 1'b0;
      lp_ctrl_ack = 1'b0;
      lp_data_ack = 1'b0;
      tick;
      reset = 1'b0;
      repeat (2) tick;
      check("rst_lp_idle", outs, 0);

      // Reset during PHYUPD
      phyupd_req = 1'b1;
      repeat (3) tick;
      check("rst_upd_pre", phyupd_ack, 1);
      reset = 1'b1;
      phyupd_req = 1'b0;
      tick;
      check("rst_upd_outs", outs, 0);
      reset = 1'b0;
      repeat (2) tick;
      check("rst_upd_idle", outs, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wav_dfi_ctrl_arb.md
# wav_dfi_ctrl_arb

MC-side DFI control-plane arbiter that owns every non-datapath DFI handshake: init_start, ctrlupd, phyupd, phymstr and lp_ctrl/lp_data. It serializes these requests through a single state machine, so the DFI forbidden combinations never occur. It enforces the tlp_resp, tctrlupd and tphyupd_resp windows and tells the memory-controller scheduler when to drain and block command/data traffic. It sits between the MC scheduler and the DFI boundary that the DFI agent drives and monitors.

## Interface
- TLP_RESP, 8: lp request window in cycles; req is withdrawn if no ack arrives within it.
- TCTRLUPD_MIN, 4: minimum ctrlupd_req high time in cycles.
- TCTRLUPD_MAX, 32: maximum ctrlupd_req high time in cycles.
- TPHYUPD_RESP, 16: cycles allowed from phyupd_req/phymstr_req to the ack.
- CNT_W, 8: width of the shared window counter; must hold TCTRLUPD_MAX.
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- mc_init_req  in  1  one-cycle pulse requesting DFI init.
- mc_ctrlupd_req  in  1  level request for a controller update.
- mc_lp_req  in  1  level request for low power; deasserting it requests exit.
- mc_lp_wakeup  in  6  wakeup code, latched when the lp request is issued.
- mc_idle  in  1  scheduler has drained all outstanding DFI traffic.
- init_complete  in  1  from PHY.
- ctrlupd_ack  in  1  from PHY.
- phyupd_req  in  1  from PHY.
- phyupd_type  in  2  from PHY.
- phymstr_req  in  1  from PHY.
- phymstr_type  in  2  from PHY.
- lp_ctrl_ack  in  1  from PHY.
- lp_data_ack  in  1  from PHY.
- init_start  out  1  DFI output.
- ctrlupd_req  out  1  DFI output.
- phyupd_ack  out  1  DFI output.
- phymstr_ack  out  1  DFI output.
- lp_ctrl_req  out  1  DFI output.
- lp_data_req  out  1  DFI output.
- lp_ctrl_wakeup  out  6  DFI output.
- lp_data_wakeup  out  6  DFI output.
- mc_block  out  1  scheduler must stop issuing commands.
- lp_active  out  1  high while both lp acks are held.
- upd_type  out  2  type latched at phyupd/phymstr grant.
- err_resp_late  out  1  one-cycle pulse when a PHY ack is granted later than TPHYUPD_RESP.

## Operation
- States: IDLE, INIT, CTRLUPD, PHYUPD, PHYMSTR, LP_REQ, LP_HOLD, LP_EXIT.
- All outputs are registered. Every output resets to 0 and the FSM resets to IDLE. Reset mid-handshake drops all reqs and acks on the next edge.
- Arbitration from IDLE uses fixed priority: init > phymstr > phyupd > ctrlupd > lp. Only one state is active at a time, so init_start, phyupd_ack, phymstr_ack, ctrlupd_req and the lp reqs are mutually exclusive.
- A pending mc_init_req pulse is captured in a sticky flag until it is serviced.
- mc_block = (state != IDLE) | phyupd_req | phymstr_req | init flag pending.
- INIT: init_start = 1 until init_complete is sampled high, then return to IDLE.
- PHYMSTR / PHYUPD:
  - Entered from IDLE when the req is high and mc_idle = 1. upd_type latches the matching type.
  - ack = 1 while in the state. On sampling req low, the state exits to IDLE and ack is 0 on the following cycle.
  - An ack granted while req is already low is forbidden, so the state is entered only on a sampled-high req.
- Response counter: counts cycles from the rising edge of phyupd_req/phymstr_req while ungranted. If the grant occurs with count > TPHYUPD_RESP, err_resp_late pulses on the grant cycle.
- CTRLUPD:
  - Entered when mc_ctrlupd_req = 1 and mc_idle = 1. ctrlupd_req = 1; the counter starts at 1.
  - If no ack has been seen by count == TCTRLUPD_MIN: drop req and go to IDLE.
  - If an ack is seen: hold req until the ack is sampled low or count == TCTRLUPD_MAX, then drop req and go to IDLE.
- LP_REQ:
  - Entered when mc_lp_req = 1 and mc_idle = 1. Both lp reqs = 1 and both wakeups = mc_lp_wakeup (latched).
  - When both acks are sampled high, go to LP_HOLD.
  - If both acks are not high after TLP_RESP cycles: reqs = 0 on the next cycle and go to IDLE. mc_lp_req must toggle low before a retry.
- LP_HOLD: lp_active = 1; reqs stay high. When mc_lp_req is sampled low, drop both reqs and go to LP_EXIT.
- LP_EXIT: wait until both acks are low, then go to IDLE. A new request is not accepted until then.
- Simultaneous events resolve by priority. Requests arriving in a non-IDLE state wait. ctrlupd and lp are never preempted.

## Timing
- IDLE to grant: one edge. A req sampled high (with mc_idle = 1) at edge k gives its output high after edge k+1.
- Release: one edge after the PHY req or ack is sampled low.
- At least one IDLE cycle occurs between any two grants.
- Counter saturates at 2^CNT_W−1 and clears on each state entry.

## Test plan
- Init: pulse mc_init_req; init_complete rises 20 cycles later → init_start high for 20 cycles, low one cycle after init_complete is sampled; mc_block low afterwards.
- Phyupd: phyupd_req=1, type=2, mc_idle=1 → phyupd_ack=1 next cycle, upd_type=2; drop req → ack 0 one cycle later; with mc_idle delayed 20 cycles → err_resp_late pulses once.
- Collision: phymstr_req and phyupd_req rise together → phymstr_ack first, phyupd_ack never concurrent; phyupd is granted after phymstr_req falls plus one IDLE cycle.
- Ctrlupd: no ack → ctrlupd_req high exactly 4 cycles; ack held 40 cycles → req drops at cycle 32.
- LP: acks never arrive → both reqs drop after 8 cycles; acks arrive at cycle 3 → LP_HOLD, lp_active=1; mc_lp_req low → reqs low, IDLE once acks low.
- Reset asserted during LP_HOLD and during PHYUPD → all outputs 0 next edge, FSM in IDLE.
